// File: rtl/status_display_ctrl.sv
// Status display controller: heartbeat, valid stretcher, sticky lockup and a
// registered seven-segment driver that runs a lamp test after every reset.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_LAMP   | lamp test, every segment lit for LAMP_TEST cycles
// ST_RUN    | status glyphs (ModeSel=0) or hex value display (ModeSel=1)
// ST_LOCKED | sticky lockup latched, blinking 'L' on every digit
module status_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int HB_MSB     = 25,
    parameter int STRETCH    = 16,
    parameter int LAMP_TEST  = 256
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [4*NUM_DIGITS-1:0] ValueIn,
    input  logic                    ModeSel,
    input  logic                    DataValid,
    input  logic                    LOCKUP,
    input  logic                    ClearLock,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    Heartbeat,
    output logic                    Running,
    output logic                    ValidStretched,
    output logic                    LockSticky
);

    localparam int SW = $clog2(STRETCH + 1);
    localparam int LW = $clog2(LAMP_TEST + 1);

    localparam logic [HB_MSB:0] HB_ONE     = 1;
    localparam logic [SW-1:0]   STR_LOAD   = SW'(STRETCH);
    localparam logic [SW-1:0]   STR_ONE    = 1;
    localparam logic [LW-1:0]   LAMP_LOAD  = LW'(LAMP_TEST - 1);
    localparam logic [LW-1:0]   LAMP_ONE   = 1;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_ALL  = 7'h00;
    localparam logic [6:0] SEG_HB   = 7'b0100011;
    localparam logic [6:0] SEG_D    = 7'b0100001;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_R    = 7'b0101111;
    localparam logic [6:0] SEG_L    = 7'b1000111;

    typedef enum logic [1:0] {
        ST_LAMP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [LW-1:0]          lamp_tmr, lamp_tmr_next;
    logic [HB_MSB:0]        hb_cnt;
    logic [SW-1:0]          stretch_cnt, stretch_next;
    logic [7*NUM_DIGITS-1:0] hex_next;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hb_cnt    <= '0;
            Heartbeat <= 1'b0;
            Running   <= 1'b0;
        end else begin
            hb_cnt    <= hb_cnt + HB_ONE;
            Heartbeat <= hb_cnt[HB_MSB] & hb_cnt[HB_MSB-2];
            Running   <= 1'b1;
        end
    end

    // A new DataValid always reloads, so back-to-back pulses merge into one window.
    always_comb begin
        stretch_next = stretch_cnt;
        if (DataValid)
            stretch_next = STR_LOAD;
        else if (stretch_cnt != '0)
            stretch_next = stretch_cnt - STR_ONE;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stretch_cnt    <= '0;
            ValidStretched <= 1'b0;
        end else begin
            stretch_cnt    <= stretch_next;
            ValidStretched <= (stretch_next != '0);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            LockSticky <= 1'b0;
        else if (LOCKUP)
            LockSticky <= 1'b1;
        else if (ClearLock)
            LockSticky <= 1'b0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_LAMP;
            lamp_tmr <= LAMP_LOAD;
        end else begin
            state    <= state_next;
            lamp_tmr <= lamp_tmr_next;
        end
    end

    always_comb begin
        state_next    = state;
        lamp_tmr_next = lamp_tmr;
        case (state)
            ST_LAMP: begin
                if (lamp_tmr == '0)
                    state_next = LockSticky ? ST_LOCKED : ST_RUN;
                else
                    lamp_tmr_next = lamp_tmr - LAMP_ONE;
            end
            ST_RUN: begin
                if (LockSticky)
                    state_next = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (!LockSticky)
                    state_next = ST_RUN;
            end
            default: state_next = ST_LAMP;
        endcase
    end

    always_comb begin
        hex_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            case (state)
                ST_RUN: begin
                    if (ModeSel)
                        hex_next[7*i +: 7] = hex_glyph(ValueIn[4*i +: 4]);
                    else if (i == 0)
                        hex_next[7*i +: 7] = Heartbeat ? SEG_HB : SEG_OFF;
                    else if (i == 1)
                        hex_next[7*i +: 7] = ValidStretched ? SEG_D : SEG_DASH;
                    else if (i == 2)
                        hex_next[7*i +: 7] = Running ? SEG_R : SEG_OFF;
                    else
                        hex_next[7*i +: 7] = SEG_OFF;
                end
                ST_LOCKED: hex_next[7*i +: 7] = hb_cnt[HB_MSB-1] ? SEG_L : SEG_OFF;
                default:   hex_next[7*i +: 7] = SEG_ALL;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            HEX <= '0;
        else
            HEX <= hex_next;
    end

endmodule

// File: doc/status_display_ctrl.md
STATUS_DISPLAY_CTRL -- requirements
Module: status_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of seven-segment digits driven (legal 1..8).
REQ-002 SHALL have parameter HB_MSB, default 25, MSB index of heartbeat counter (legal >= 2).
REQ-003 SHALL have parameter STRETCH, default 16, cycles DataValid indication is held after last pulse (legal >= 1).
REQ-004 SHALL have parameter LAMP_TEST, default 256, cycles of all-segments-lit after reset (legal >= 1).
REQ-005 SHALL have one clock and asynchronous active-low reset: HCLK  in  1  rising-edge clock; HRESETn  in  1  asynchronous active-low reset.
REQ-006 ValueIn  in  4*NUM_DIGITS  hex value; nibble i shown on digit i in value mode.
REQ-007 ModeSel  in  1  0 = status glyphs, 1 = hex value display.
REQ-008 DataValid  in  1  single-cycle or level valid indication.
REQ-009 LOCKUP  in  1  processor lockup indication.
REQ-010 ClearLock  in  1  request to clear sticky lockup.
REQ-011 HEX  out  7*NUM_DIGITS  active-low segments; digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}.
REQ-012 Heartbeat  out  1; Running  out  1; ValidStretched  out  1; LockSticky  out  1.

Function
REQ-013 SHALL keep a free-running (HB_MSB+1)-bit counter incrementing every cycle, wrapping all-ones -> 0.
REQ-014 Heartbeat SHALL be a register loaded each cycle with cnt[HB_MSB] AND cnt[HB_MSB-2] (one cycle behind counter).
REQ-015 Running SHALL go 1 on the first clock edge after reset release and stay 1.
REQ-016 Stretcher: DataValid=1 SHALL load counter with STRETCH; otherwise nonzero counter decrements; ValidStretched = (counter != 0), registered; DataValid=1 while counting SHALL reload (retrigger), including when counter = 1.
REQ-017 LockSticky SHALL set on any cycle LOCKUP=1, in any state; SHALL clear only when ClearLock=1 and LOCKUP=0 in the same cycle; LOCKUP=1 wins over ClearLock.
REQ-018 FSM states LAMP, RUN, LOCKED; reset enters LAMP.
REQ-019 LAMP: HEX all 0 (all segments lit) for exactly LAMP_TEST cycles, then -> LOCKED if LockSticky else -> RUN.
REQ-020 RUN -> LOCKED on the cycle after LockSticky is 1; LOCKED -> RUN on the cycle after LockSticky clears.
REQ-021 RUN, ModeSel=0: digit0 = 7'b0100011 if Heartbeat else 7'h7F; digit1 = 7'b0100001 ('d') if ValidStretched else 7'b0111111 ('-'); digit2 = 7'b0101111 ('r') if Running else 7'h7F; digits >= 3 = 7'h7F; digits beyond NUM_DIGITS omitted.
REQ-022 RUN, ModeSel=1: digit i = standard active-low hex decode of ValueIn[4i+3:4i] (0 = 7'b1000000, 1 = 7'b1111001, ..., F = 7'b0001110).
REQ-023 LOCKED: all digits 7'b1000111 ('L') when cnt[HB_MSB-1]=1, 7'h7F otherwise (blink).
REQ-024 HEX SHALL be registered: one-cycle latency from ValueIn/ModeSel/state to HEX.
REQ-025 ModeSel change mid-run SHALL take effect on next HEX update with no glitch state.

Reset
REQ-026 HRESETn=0 SHALL immediately force: counter 0, Heartbeat 0, Running 0, stretcher 0, ValidStretched 0, LockSticky 0, state LAMP, HEX all 0.
REQ-027 Reset asserted mid-operation (any state) SHALL abort and restart the full LAMP_TEST period after release.

Verification (NUM_DIGITS=4, HB_MSB=3, STRETCH=3, LAMP_TEST=4)
REQ-028 Release reset -> HEX=28'h0 for 4 cycles, then status glyphs; Running=1 from first edge; digit2=7'b0101111.
REQ-029 Free-run 32 cycles -> Heartbeat=1 exactly when registered cnt was 4'b1x1x (cnt 10,11,14,15), one cycle later; counter wraps 15 -> 0.
REQ-030 DataValid 1-cycle pulse, then another pulse 2 cycles later -> ValidStretched high continuously until 3 cycles after second pulse; digit1 'd' then '-'.
REQ-031 ModeSel=1, ValueIn=16'hA5C3 -> HEX next cycle digits3..0 = 'A','5','C','3' (7'b0001000, 7'b0010010, 7'b1000110, 7'b0110000).
REQ-032 LOCKUP pulse during LAMP -> LOCKED after lamp test, 'L' blinking with cnt[2]; ClearLock=1 with LOCKUP=1 -> stays LOCKED; ClearLock=1 with LOCKUP=0 -> LockSticky 0, RUN next cycle.
REQ-033 Assert HRESETn=0 while LOCKED -> all outputs to reset values asynchronously, LockSticky 0, LAMP restarts on release.
